alu_mdu: RTL and testbench



---
 rtl/alu_mdu.sv | 148 ++++++++++++++
 tb/tb_alu_mdu.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/alu_mdu.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// One radix-2 step per cycle: shift-add multiply, restoring divide.
module alu_mdu #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MTHI = 6'b010001;
  localparam logic [5:0] F_MFLO = 6'b010010;
  localparam logic [5:0] F_MTLO = 6'b010011;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t            state, state_nxt;
  logic [CNTW-1:0]   cnt;
  logic [WIDTH-1:0]  wh, wl, opb;       // working high/low halves, divisor/multiplicand
  logic              is_div, neg_lo, neg_hi, dz;

  // MDU class covers 010000..010011 and 011000..011011
  logic mdu_cls, start, signed_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign mdu_cls   = (funct[5:4] == 2'b01) && !funct[2];
  assign start     = en && (state == IDLE) && (funct[5:2] == 4'b0110);
  assign signed_op = !funct[0];
  assign a_neg     = signed_op && a[WIDTH-1];
  assign b_neg     = signed_op && b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  assign busy  = (state != IDLE);
  assign stall = en && mdu_cls && busy;

  // Register reads only while idle; anything else reads as zero
  always_comb begin
    rdata = '0;
    if (en && !busy) begin
      if (funct == F_MFHI) rdata = hi;
      else if (funct == F_MFLO) rdata = lo;
    end
  end

  // One iteration step for both multiply and divide
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] wh_nxt, wl_nxt;
  always_comb begin
    mul_sum  = {1'b0, wh} + (wl[0] ? {1'b0, opb} : '0);
    div_sh   = {wh, wl[WIDTH-1]};
    div_diff = div_sh - {1'b0, opb};
    div_ge   = !div_diff[WIDTH];
    if (is_div) begin
      wh_nxt = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
      wl_nxt = {wl[WIDTH-2:0], div_ge};
    end else begin
      wh_nxt = mul_sum[WIDTH:1];
      wl_nxt = {mul_sum[0], wl[WIDTH-1:1]};
    end
  end

  // Sign fix-up: full-width negate for products, per-half for quotient/remainder
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   hi_fix, lo_fix;
  always_comb begin
    prod_fix = neg_lo ? -{wh, wl} : {wh, wl};
    if (is_div) begin
      lo_fix = dz ? '1 : (neg_lo ? -wl : wl);
      hi_fix = neg_hi ? -wh : wh;
    end else begin
      lo_fix = prod_fix[WIDTH-1:0];
      hi_fix = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (cnt == CNTW'(WIDTH - 1)) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, datapath and architectural registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      wh     <= '0;
      wl     <= '0;
      opb    <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      dz     <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state <= state_nxt;
      done  <= (state == FIX);
      case (state)
        IDLE: begin
          if (start) begin
            cnt    <= '0;
            is_div <= funct[1];
            wh     <= '0;
            wl     <= funct[1] ? a_mag : b_mag;
            opb    <= funct[1] ? b_mag : a_mag;
            dz     <= funct[1] && (b == '0);
            neg_lo <= a_neg ^ b_neg;
            neg_hi <= a_neg;
          end else if (en && funct == F_MTHI) begin
            hi <= a;
          end else if (en && funct == F_MTLO) begin
            lo <= a;
          end
        end
        RUN: begin
          wh  <= wh_nxt;
          wl  <= wl_nxt;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          hi <= hi_fix;
          lo <= lo_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu: moves, mul/div results, latency, stall, reset abort.
module tb_alu_mdu;
  localparam int W = 32;
  localparam logic [5:0] MFHI = 6'b010000, MTHI = 6'b010001, MFLO = 6'b010010, MTLO = 6'b010011;
  localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001, DIV = 6'b011010, DIVU = 6'b011011;

  logic clk = 0, reset = 1, en = 0;
  logic [5:0] funct = '0;
  logic [W-1:0] a = '0, b = '0;
  logic [W-1:0] rdata, hi, lo;
  logic busy, stall, done;
  int n_pass = 0, n_total = 0;

  alu_mdu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .en(en), .funct(funct), .a(a), .b(b),
    .rdata(rdata), .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issue a start in the current cycle and wait for done; returns cycle index of done.
  task automatic run_op(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int cyc);
    en = 1; funct = f; a = x; b = y;
    tick(); en = 0; cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin tick(); cyc++; end
  endtask

  task automatic test_reset();
    reset = 1; tick(); tick();
    n_total++; if (hi !== '0 || lo !== '0) $display("FAIL reset_hilo hi=%h lo=%h want 0", hi, lo); else n_pass++;
    n_total++; if (busy !== 0 || done !== 0 || stall !== 0 || rdata !== '0)
      $display("FAIL reset_ctl busy=%b done=%b stall=%b rdata=%h want 0", busy, done, stall, rdata); else n_pass++;
    reset = 0; tick();
  endtask

  task automatic test_moves();
    int dseen = 0;
    en = 1; funct = MTHI; a = 32'h1234_5678; tick(); if (done) dseen++;
    funct = MTLO; a = 32'hDEAD_BEEF; tick(); if (done) dseen++;
    funct = MFHI; a = '0; #1;
    n_total++; if (rdata !== 32'h1234_5678) $display("FAIL mfhi rdata=%h want 12345678", rdata); else n_pass++;
    funct = MFLO; #1;
    n_total++; if (rdata !== 32'hDEAD_BEEF) $display("FAIL mflo rdata=%h want deadbeef", rdata); else n_pass++;
    // non-MDU funct: no effect, no stall, zero rdata
    funct = 6'b100000; a = 32'hFFFF; #1;
    n_total++; if (stall !== 0 || rdata !== '0) $display("FAIL other_funct stall=%b rdata=%h want 0/0", stall, rdata); else n_pass++;
    tick(); if (done) dseen++; tick(); if (done) dseen++;
    en = 0;
    n_total++; if (hi !== 32'h1234_5678 || lo !== 32'hDEAD_BEEF || dseen != 0)
      $display("FAIL moves_hold hi=%h lo=%h dones=%0d want 12345678 deadbeef 0", hi, lo, dseen); else n_pass++;
  endtask

  task automatic test_mult();
    int cyc;
    run_op(MULT, 32'hFFFF_FFFE, 32'h3, cyc);
    n_total++; if (cyc != W + 2) $display("FAIL mult_latency cycle=%0d want %0d", cyc, W + 2); else n_pass++;
    n_total++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA)
      $display("FAIL mult hi=%h lo=%h want ffffffff fffffffa", hi, lo); else n_pass++;
    tick();
    n_total++; if (done !== 0) $display("FAIL done_pulse done=%b want 0", done); else n_pass++;
    run_op(MULTU, 32'hFFFF_FFFE, 32'h3, cyc);
    n_total++; if (hi !== 32'h2 || lo !== 32'hFFFF_FFFA || cyc != W + 2)
      $display("FAIL multu hi=%h lo=%h cyc=%0d want 2 fffffffa 34", hi, lo, cyc); else n_pass++;
    // back-to-back: start in the done cycle
    run_op(MULT, 32'hFFFF_FFFF, 32'h7, cyc);
    n_total++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF9 || cyc != W + 2)
      $display("FAIL mult_b2b hi=%h lo=%h cyc=%0d want ffffffff fffffff9 34", hi, lo, cyc); else n_pass++;
  endtask

  task automatic test_div();
    int cyc;
    run_op(DIV, 32'hFFFF_FFF9, 32'h2, cyc);
    n_total++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF || cyc != W + 2)
      $display("FAIL div_neg lo=%h hi=%h cyc=%0d want fffffffd ffffffff 34", lo, hi, cyc); else n_pass++;
    run_op(DIVU, 32'd100, 32'd7, cyc);
    n_total++; if (lo !== 32'd14 || hi !== 32'd2) $display("FAIL divu lo=%0d hi=%0d want 14 2", lo, hi); else n_pass++;
    run_op(DIVU, 32'h55, 32'h0, cyc);
    n_total++; if (lo !== 32'hFFFF_FFFF || hi !== 32'h55 || cyc != W + 2)
      $display("FAIL divu_zero lo=%h hi=%h cyc=%0d want ffffffff 55 34", lo, hi, cyc); else n_pass++;
    run_op(DIV, 32'hFFFF_FFF9, 32'h0, cyc);
    n_total++; if (lo !== 32'hFFFF_FFFF || hi !== 32'hFFFF_FFF9)
      $display("FAIL div_zero lo=%h hi=%h want ffffffff fffffff9", lo, hi); else n_pass++;
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    n_total++; if (lo !== 32'h8000_0000 || hi !== 32'h0)
      $display("FAIL div_ovf lo=%h hi=%h want 80000000 0", lo, hi); else n_pass++;
  endtask

  task automatic test_stall();
    int cyc, nst;
    en = 1; funct = MULT; a = 32'd6; b = 32'd7;
    tick(); cyc = 1; nst = 0;
    funct = MFLO; #1;
    n_total++; if (busy !== 1) $display("FAIL busy_start busy=%b want 1", busy); else n_pass++;
    while (done !== 1'b1 && cyc < 200) begin if (stall) nst++; tick(); cyc++; end
    n_total++; if (nst != W + 1 || cyc != W + 2)
      $display("FAIL stall_count stalls=%0d cyc=%0d want %0d %0d", nst, cyc, W + 1, W + 2); else n_pass++;
    n_total++; if (stall !== 0 || rdata !== 32'd42)
      $display("FAIL mflo_done stall=%b rdata=%h want 0 2a", stall, rdata); else n_pass++;
    en = 0;
    // MTHI while busy is dropped
    en = 1; funct = MULTU; a = 32'h1_0000; b = 32'h1_0000;
    tick(); en = 0; tick(); tick();
    en = 1; funct = MTHI; a = 32'hAAAA; #1;
    n_total++; if (stall !== 1) $display("FAIL mthi_busy_stall stall=%b want 1", stall); else n_pass++;
    tick(); en = 0; cyc = 4;
    while (done !== 1'b1 && cyc < 200) begin tick(); cyc++; end
    n_total++; if (hi !== 32'h1 || lo !== 32'h0 || cyc != W + 2)
      $display("FAIL mthi_ignored hi=%h lo=%h cyc=%0d want 1 0 34", hi, lo, cyc); else n_pass++;
  endtask

  task automatic test_reset_abort();
    int dseen = 0, cyc;
    en = 1; funct = DIVU; a = 32'd100; b = 32'd7;
    tick(); en = 0;
    repeat (9) tick();
    reset = 1; tick(); reset = 0;
    n_total++; if (busy !== 0 || hi !== '0 || lo !== '0)
      $display("FAIL abort busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo); else n_pass++;
    repeat (40) begin if (done) dseen++; tick(); end
    n_total++; if (dseen != 0 || hi !== '0 || lo !== '0)
      $display("FAIL abort_nodone dones=%0d hi=%h lo=%h want 0", dseen, hi, lo); else n_pass++;
    run_op(MULTU, 32'd3, 32'd5, cyc);
    n_total++; if (lo !== 32'd15 || hi !== 32'd0 || cyc != W + 2)
      $display("FAIL multu_after lo=%0d hi=%0d cyc=%0d want 15 0 34", lo, hi, cyc); else n_pass++;
  endtask

  initial begin
    #1;
    test_reset();
    test_moves();
    test_mult();
    test_div();
    test_stall();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
